// File: rtl/decodificador_seq.sv
// decodificador_seq: programmable N-step symbol sequence validator.
// Accepts a table-driven sequence of W-bit symbols, one per strobe, with
// one-step corrections, two position-dependent terminal symbols and a
// sticky error state. Keeps a saturating count of error entries.
//
// Ports:
//   clk        rising-edge clock
//   Reset      asynchronous active-low reset (clears FSM, table and Erros)
//   Controle   symbol strobe; Entrada is sampled only when high
//   Entrada    W-bit symbol code
//   Reinicio   synchronous restart to IDLE (keeps table and Erros)
//   Prog_en    table write enable; also forces IDLE
//   Prog_addr  table address: 0..N-1 seq, N Fim_A, N+1 Fim_B, N+2 Aborto
//   Prog_dado  table write data
//   Saida      verdict: 00 running/idle, 01 accepted A, 10 accepted B, 11 error
//   Estado     current step 0..N
//   Pronto     one-cycle pulse on entry to any terminal state
//   Erros      saturating count of transitions into the error state
module decodificador_seq #(
    parameter int unsigned W  = 7,
    parameter int unsigned N  = 5,
    parameter int unsigned K  = 3,
    parameter int unsigned CW = 8,
    localparam int unsigned SW = $clog2(N + 1),
    localparam int unsigned AW = $clog2(N + 3)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Controle,
    input  logic [W-1:0]  Entrada,
    input  logic          Reinicio,
    input  logic          Prog_en,
    input  logic [AW-1:0] Prog_addr,
    input  logic [W-1:0]  Prog_dado,
    output logic [1:0]    Saida,
    output logic [SW-1:0] Estado,
    output logic          Pronto,
    output logic [CW-1:0] Erros
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASSO,
        ST_ACEITO_A,
        ST_ACEITO_B,
        ST_ERRO
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [SW-1:0] step;
    logic [SW-1:0] step_d;

    logic [W-1:0]  seq_tab [N];
    logic [W-1:0]  fim_a;
    logic [W-1:0]  fim_b;
    logic [W-1:0]  aborto;

    logic          adv_hit;
    logic          corr_hit;

    logic [1:0]    saida_d;
    logic          pronto_d;
    logic [CW-1:0] erros_d;

    function automatic logic is_term(input state_t s);
        return (s == ST_ACEITO_A) || (s == ST_ACEITO_B) || (s == ST_ERRO);
    endfunction

    // Symbol table; writes land at the edge and are visible the next cycle
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                seq_tab[i] <= '0;
            end
            fim_a  <= '0;
            fim_b  <= '0;
            aborto <= '0;
        end else if (Prog_en) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(Prog_addr) == i) begin
                    seq_tab[i] <= Prog_dado;
                end
            end
            if (32'(Prog_addr) == N)     fim_a  <= Prog_dado;
            if (32'(Prog_addr) == N + 1) fim_b  <= Prog_dado;
            if (32'(Prog_addr) == N + 2) aborto <= Prog_dado;
        end
    end

    // Advance compares against seq[step], correction against seq[step-2];
    // the index loop keeps both lookups in range without explicit guards.
    always_comb begin
        adv_hit  = 1'b0;
        corr_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if ((32'(step) == i) && (Entrada == seq_tab[i])) begin
                adv_hit = 1'b1;
            end
            if ((32'(step) == i + 2) && (Entrada == seq_tab[i])) begin
                corr_hit = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            state <= state_d;
            step  <= step_d;
        end
    end

    // Next-state logic: Prog_en > Reinicio > symbol strobe
    always_comb begin
        state_d = state;
        step_d  = step;
        if (Prog_en || Reinicio) begin
            state_d = ST_IDLE;
            step_d  = '0;
        end else if (Controle) begin
            case (state)
                ST_IDLE: begin
                    if (Entrada == seq_tab[0]) begin
                        state_d = ST_PASSO;
                        step_d  = SW'(1);
                    end else begin
                        state_d = ST_ERRO;
                    end
                end
                ST_PASSO: begin
                    if (adv_hit) begin
                        step_d = step + SW'(1);
                    end else if (corr_hit) begin
                        step_d = step - SW'(1);
                    end else if ((Entrada == fim_a) && (32'(step) <= K)) begin
                        state_d = ST_ACEITO_A;
                    end else if ((Entrada == fim_b) && (32'(step) > K)) begin
                        state_d = ST_ACEITO_B;
                    end else if (Entrada == aborto) begin
                        state_d = ST_ERRO;
                    end else begin
                        // skip-ahead, repeat, out-of-range terminal, overrun
                        state_d = ST_ERRO;
                    end
                end
                default: begin
                    // terminal states are sticky
                    state_d = state;
                end
            endcase
        end
    end

    // Output logic computed from the next state, then registered
    always_comb begin
        saida_d  = 2'b00;
        pronto_d = 1'b0;
        erros_d  = Erros;
        case (state_d)
            ST_ACEITO_A: saida_d = 2'b01;
            ST_ACEITO_B: saida_d = 2'b10;
            ST_ERRO:     saida_d = 2'b11;
            default:     saida_d = 2'b00;
        endcase
        pronto_d = is_term(state_d) && !is_term(state);
        if ((state_d == ST_ERRO) && (state != ST_ERRO) && (Erros != '1)) begin
            erros_d = Erros + CW'(1);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Saida  <= 2'b00;
            Pronto <= 1'b0;
            Erros  <= '0;
        end else begin
            Saida  <= saida_d;
            Pronto <= pronto_d;
            Erros  <= erros_d;
        end
    end

    assign Estado = step;

endmodule

// File: tb/tb_decodificador_seq.sv
// tb_decodificador_seq: directed test of decodificador_seq.
// dut  : W=7, N=5, K=3, CW=8 (main sequence table)
// dut2 : W=7, N=8, K=5, CW=2 (reprogrammed length and counter saturation)
module tb_decodificador_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       reset = 1'b0;
    logic       controle = 1'b0;
    logic [6:0] entrada = '0;
    logic       reinicio = 1'b0;
    logic       prog_en = 1'b0;
    logic [2:0] prog_addr = '0;
    logic [6:0] prog_dado = '0;
    logic [1:0] saida;
    logic [2:0] estado;
    logic       pronto;
    logic [7:0] erros;

    // second instance
    logic       reset2 = 1'b0;
    logic       controle2 = 1'b0;
    logic [6:0] entrada2 = '0;
    logic       reinicio2 = 1'b0;
    logic       prog_en2 = 1'b0;
    logic [3:0] prog_addr2 = '0;
    logic [6:0] prog_dado2 = '0;
    logic [1:0] saida2;
    logic [3:0] estado2;
    logic       pronto2;
    logic [1:0] erros2;

    decodificador_seq #(.W(7), .N(5), .K(3), .CW(8)) dut (
        .clk(clk), .Reset(reset), .Controle(controle), .Entrada(entrada),
        .Reinicio(reinicio), .Prog_en(prog_en), .Prog_addr(prog_addr),
        .Prog_dado(prog_dado), .Saida(saida), .Estado(estado),
        .Pronto(pronto), .Erros(erros)
    );

    decodificador_seq #(.W(7), .N(8), .K(5), .CW(2)) dut2 (
        .clk(clk), .Reset(reset2), .Controle(controle2), .Entrada(entrada2),
        .Reinicio(reinicio2), .Prog_en(prog_en2), .Prog_addr(prog_addr2),
        .Prog_dado(prog_dado2), .Saida(saida2), .Estado(estado2),
        .Pronto(pronto2), .Erros(erros2)
    );

    localparam logic [6:0] FA = 7'b1001001;
    localparam logic [6:0] FB = 7'b1010011;
    localparam logic [6:0] AB = 7'b1110101;
    logic [6:0] c [5] = '{7'b1100000, 7'b1000100, 7'b1111100, 7'b1011010, 7'b1101110};

    int total = 0;
    int bad = 0;
    int exp_err = 0;

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic sym(input logic [6:0] x);
        controle = 1'b1;
        entrada  = x;
        @(posedge clk); #1;
        controle = 1'b0;
    endtask

    task automatic restart();
        reinicio = 1'b1;
        @(posedge clk); #1;
        reinicio = 1'b0;
    endtask

    task automatic prog(input logic [2:0] a, input logic [6:0] d);
        prog_en   = 1'b1;
        prog_addr = a;
        prog_dado = d;
        @(posedge clk); #1;
        prog_en = 1'b0;
    endtask

    task automatic run_to(input int s);
        for (int i = 0; i < s; i++) sym(c[i]);
    endtask

    task automatic sym2(input logic [6:0] x);
        controle2 = 1'b1;
        entrada2  = x;
        @(posedge clk); #1;
        controle2 = 1'b0;
    endtask

    task automatic restart2();
        reinicio2 = 1'b1;
        @(posedge clk); #1;
        reinicio2 = 1'b0;
    endtask

    task automatic prog2(input logic [3:0] a, input logic [6:0] d);
        prog_en2   = 1'b1;
        prog_addr2 = a;
        prog_dado2 = d;
        @(posedge clk); #1;
        prog_en2 = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        total++;
        if ({saida, estado, pronto, erros} !== 14'd0) begin
            $display("FAIL reset_state: got saida=%b estado=%0d pronto=%b erros=%0d, want all 0",
                     saida, estado, pronto, erros);
            bad++;
        end
        @(posedge clk); #1;
        reset  = 1'b1;
        reset2 = 1'b1;
        // cleared table: all-zero symbol matches seq[0]
        sym(7'd0);
        total++;
        if ({saida, estado} !== {2'b00, 3'd1}) begin
            $display("FAIL reset_table_zero: got saida=%b estado=%0d, want 00/1", saida, estado);
            bad++;
        end
        restart();
    endtask

    task automatic test_program_and_advance();
        for (int i = 0; i < 5; i++) prog(3'(i), c[i]);
        prog(3'd5, FA);
        prog(3'd6, FB);
        prog(3'd7, AB);
        total++;
        if ({saida, estado} !== 5'd0) begin
            $display("FAIL prog_idle: got saida=%b estado=%0d, want 00/0", saida, estado);
            bad++;
        end
        for (int i = 0; i < 5; i++) begin
            sym(c[i]);
            total++;
            if ({saida, estado, pronto} !== {2'b00, 3'(i + 1), 1'b0}) begin
                $display("FAIL advance_%0d: got saida=%b estado=%0d pronto=%b, want 00/%0d/0",
                         i + 1, saida, estado, pronto, i + 1);
                bad++;
            end
        end
    endtask

    task automatic test_correction();
        // starts at step 5
        for (int j = 3; j >= 0; j--) begin
            sym(c[j]);
            total++;
            if ({saida, estado, pronto} !== {2'b00, 3'(j + 1), 1'b0}) begin
                $display("FAIL correct_to_%0d: got saida=%b estado=%0d pronto=%b",
                         j + 1, saida, estado, pronto);
                bad++;
            end
        end
        sym(c[0]);
        exp_err++;
        total++;
        if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
            $display("FAIL repeat_error: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
        sym(c[1]);
        total++;
        if ({saida, pronto} !== 3'b110 || erros !== 8'(exp_err)) begin
            $display("FAIL error_sticky: got saida=%b pronto=%b erros=%0d, want 11/0/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
    endtask

    task automatic test_terminal();
        restart();
        total++;
        if ({saida, estado, pronto} !== 6'd0) begin
            $display("FAIL reinicio_clear: got saida=%b estado=%0d pronto=%b, want 0",
                     saida, estado, pronto);
            bad++;
        end
        run_to(3); sym(FA);
        total++;
        if ({saida, pronto} !== 3'b011) begin
            $display("FAIL fim_a_step3: got saida=%b pronto=%b, want 01/1", saida, pronto);
            bad++;
        end
        sym(c[0]);
        total++;
        if ({saida, pronto} !== 3'b010) begin
            $display("FAIL accept_sticky: got saida=%b pronto=%b, want 01/0", saida, pronto);
            bad++;
        end
        restart(); run_to(1); sym(FA);
        total++;
        if ({saida, pronto} !== 3'b011) begin
            $display("FAIL fim_a_step1: got saida=%b pronto=%b, want 01/1", saida, pronto);
            bad++;
        end
        restart(); run_to(4); sym(FB);
        total++;
        if ({saida, pronto} !== 3'b101) begin
            $display("FAIL fim_b_step4: got saida=%b pronto=%b, want 10/1", saida, pronto);
            bad++;
        end
        restart(); run_to(5); sym(FB);
        total++;
        if ({saida, pronto} !== 3'b101) begin
            $display("FAIL fim_b_step5: got saida=%b pronto=%b, want 10/1", saida, pronto);
            bad++;
        end
        restart(); run_to(4); sym(FA);
        exp_err++;
        total++;
        if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
            $display("FAIL fim_a_step4: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
        restart(); run_to(3); sym(FB);
        exp_err++;
        total++;
        if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
            $display("FAIL fim_b_step3: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
    endtask

    task automatic test_abort_illegal();
        for (int s = 1; s <= 5; s++) begin
            restart(); run_to(s); sym(AB);
            exp_err++;
            total++;
            if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
                $display("FAIL abort_step%0d: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                         s, saida, pronto, erros, exp_err);
                bad++;
            end
        end
        restart(); sym(c[0]); sym(c[2]);
        exp_err++;
        total++;
        if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
            $display("FAIL skip: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
        restart(); run_to(3); sym(c[0]);
        exp_err++;
        total++;
        if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
            $display("FAIL nonadjacent_corr: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
        restart(); sym(c[1]);
        exp_err++;
        total++;
        if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
            $display("FAIL idle_wrong: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
    endtask

    task automatic test_reinicio_priority();
        restart();
        reinicio = 1'b1;
        controle = 1'b1;
        entrada  = c[0];
        @(posedge clk); #1;
        reinicio = 1'b0;
        controle = 1'b0;
        total++;
        if ({saida, estado, pronto} !== 6'd0) begin
            $display("FAIL reinicio_priority: got saida=%b estado=%0d pronto=%b, want 0",
                     saida, estado, pronto);
            bad++;
        end
    endtask

    task automatic test_prog_mid();
        restart(); run_to(2);
        prog(3'd0, 7'h11);
        total++;
        if ({saida, estado} !== 5'd0) begin
            $display("FAIL prog_mid: got saida=%b estado=%0d, want 00/0", saida, estado);
            bad++;
        end
        sym(7'h11); sym(c[1]);
        total++;
        if ({saida, estado} !== {2'b00, 3'd2}) begin
            $display("FAIL prog_new_entry: got saida=%b estado=%0d, want 00/2", saida, estado);
            bad++;
        end
        prog(3'd0, c[0]);
    endtask

    task automatic test_reset_mid();
        restart(); run_to(3);
        #2;
        reset = 1'b0;
        #1;
        exp_err = 0;
        total++;
        if ({saida, estado, pronto, erros} !== 14'd0) begin
            $display("FAIL reset_mid: got saida=%b estado=%0d pronto=%b erros=%0d, want 0",
                     saida, estado, pronto, erros);
            bad++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        // table was cleared, so C1 no longer matches seq[0]
        sym(c[0]);
        exp_err++;
        total++;
        if ({saida, pronto} !== 3'b111 || erros !== 8'(exp_err)) begin
            $display("FAIL reset_cleared_table: got saida=%b pronto=%b erros=%0d, want 11/1/%0d",
                     saida, pronto, erros, exp_err);
            bad++;
        end
    endtask

    task automatic test_saturation();
        for (int n = 1; n <= 6; n++) begin
            sym2(7'h01);
            total++;
            if (saida2 !== 2'b11 || erros2 !== 2'((n > 3) ? 3 : n)) begin
                $display("FAIL sat_%0d: got saida=%b erros=%0d, want 11/%0d",
                         n, saida2, erros2, (n > 3) ? 3 : n);
                bad++;
            end
            restart2();
        end
    endtask

    task automatic test_n8();
        for (int i = 0; i < 8; i++) prog2(4'(i), 7'(i + 1));
        prog2(4'd8, 7'h40);
        prog2(4'd9, 7'h41);
        prog2(4'd10, 7'h42);
        for (int i = 0; i < 8; i++) begin
            sym2(7'(i + 1));
            total++;
            if ({saida2, estado2} !== {2'b00, 4'(i + 1)}) begin
                $display("FAIL n8_step%0d: got saida=%b estado=%0d", i + 1, saida2, estado2);
                bad++;
            end
        end
        sym2(7'h41);
        total++;
        if ({saida2, pronto2} !== 3'b101 || erros2 !== 2'd3) begin
            $display("FAIL n8_fim_b: got saida=%b pronto=%b erros=%0d, want 10/1/3",
                     saida2, pronto2, erros2);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_program_and_advance();
        test_correction();
        test_terminal();
        test_abort_illegal();
        test_reinicio_priority();
        test_prog_mid();
        test_reset_mid();
        test_saturation();
        test_n8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decodificador_seq.md
# decodificador_seq

Parametrised successor to the fixed 7-bit character decoder. It validates a programmable sequence of N symbols of W bits, presented one per strobe. It supports one-step corrections, two terminal symbols whose acceptance depends on sequence position, and a sticky error state. It sits between the symbol source and the control logic that consumes the accept/error verdict, and it keeps a saturating error count for diagnostics.

## Interface
- W, 7: symbol width in bits.
- N, 5: sequence length (number of steps), N ≥ 2.
- K, 3: split point, 1 ≤ K < N.
  - Fim_A is accepted at steps 1..K.
  - Fim_B is accepted at steps K+1..N.
- CW, 8: error counter width.
- Derived: SW = clog2(N+1); AW = clog2(N+3).

Ports:
- clk  in  1: single clock, rising edge.
- Reset  in  1: asynchronous, active-low reset.
- Controle  in  1: symbol strobe. Entrada is sampled only when it is 1.
- Entrada  in  W: symbol code.
- Reinicio  in  1: synchronous restart to IDLE. Does not clear the table or the error counter.
- Prog_en  in  1: table write enable.
- Prog_addr  in  AW: table address.
  - 0..N-1: sequence entries seq[0..N-1].
  - N: Fim_A.
  - N+1: Fim_B.
  - N+2: Aborto.
  - Addresses > N+2 are ignored.
- Prog_dado  in  W: table write data.
- Saida  out  2: verdict. 00 running/idle, 01 accepted A, 10 accepted B, 11 error.
- Estado  out  SW: current step, 0..N.
- Pronto  out  1: one-cycle pulse on entry to any terminal state.
- Erros  out  CW: saturating count of error entries.

## Operation
- FSM states: IDLE (step 0), PASSO (step s = 1..N), ACEITO_A, ACEITO_B, ERRO.
- Symbol events are processed only when Controle=1, Prog_en=0 and Reinicio=0.
- Transitions from IDLE:
  - seq[0] → PASSO, s=1.
  - Anything else → ERRO.
- Transitions from PASSO s, evaluated in priority order (first match wins):
  1. Advance: s<N and Entrada=seq[s] → s+1.
  2. Correction: s≥2 and Entrada=seq[s-2] → s-1.
  3. Entrada=Fim_A and s≤K → ACEITO_A.
  4. Entrada=Fim_B and s>K → ACEITO_B.
  5. Entrada=Aborto → ERRO.
  6. Anything else → ERRO. This covers:
     - skipping ahead;
     - repeating the current symbol;
     - a terminal symbol outside its range;
     - any symbol other than a correction or terminal at s=N.
- ACEITO_A, ACEITO_B, ERRO are sticky. Symbols are ignored until Reinicio or Reset.
- Reinicio=1 → IDLE at the next edge and has priority over symbols. Saida=00, Estado=0.
- Prog_en=1:
  - Writes Prog_dado to Prog_addr at the edge.
  - Forces IDLE, with priority over Reinicio and symbols.
  - The new entry is used from the next cycle.
- Erros increments by 1 on each transition into ERRO and saturates at 2^CW−1. Only Reset clears it.

## Timing
- Reset low (asynchronous):
  - FSM=IDLE, Estado=0, Saida=00, Pronto=0, Erros=0.
  - All table entries=0. An all-zero symbol then matches seq[0] until the table is programmed.
- All outputs are registered. A symbol sampled at edge t is reflected on Saida/Estado immediately after edge t (one-edge latency, no combinational path from input to output).
- Pronto:
  - High for exactly the cycle after the edge that enters ACEITO_A, ACEITO_B or ERRO.
  - Never reasserts while the FSM remains in that state.
- Back-to-back strobes, one per cycle, are fully supported with no bubbles.
- Reset asserted mid-sequence aborts immediately. Release is synchronised by the first rising edge with Reset high.
- Reinicio and Controle in the same cycle: Reinicio wins and the symbol is dropped.
- Code collisions in the table are resolved by the priority order above.

## Test plan
Unless stated otherwise, the table holds W=7, N=5, K=3 with:
- seq = 1100000, 1000100, 1111100, 1011010, 1101110;
- Fim_A = 1001001, Fim_B = 1010011, Aborto = 1110101.

1. Program the table → then strobe C1..C5 → Estado = 1,2,3,4,5 on consecutive cycles; Saida=00; Pronto=0.
2. C1..C5, then C4, C3, C2, C1 → Estado = 4,3,2,1. Then C1 at step 1 → ERRO, Saida=11, Pronto pulse, Erros=1.
3. Terminal acceptance, each preceded by Reinicio:
   - Sequence to step 3, then 1001001 → Saida=01.
   - Sequence to step 4, then 1010011 → Saida=10.
   - Sequence to step 4, then 1001001 → Saida=11.
4. Aborto and illegal symbols:
   - From steps 1..5, 1110101 → Saida=11.
   - Skip: C1, C3 → Saida=11.
   - Non-adjacent correction: C1..C3, then C1 → Saida=11.
5. Boundaries:
   - Reset low mid-sequence at step 3 → all outputs 0 asynchronously and the table is cleared.
   - Reinicio together with Controle and C1 → stays IDLE.
   - Force 2^CW+2 errors with CW=2 → Erros saturates at 3.
6. Reprogramming:
   - N=8, K=5: program 8 entries, then run a full sequence and Fim_B → Saida=10.
   - Prog_en mid-sequence → Estado=0 on the next cycle.
